// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the N-master memory bus arbiter: FSM state
// encodings, arbitration mode codes and an index-width helper.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ACK   = 2'd3
  } state_e;

  localparam logic PRIO_RR    = 1'b0;
  localparam logic PRIO_FIXED = 1'b1;

  // Index width for a master count; never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_arbiter.sv
// Combinational request picker: round-robin from a pointer or fixed priority
// (index 0 highest), returning a one-hot grant and its binary index.
module rr_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  input  logic          i_mode,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_cand;
  logic          w_hit;

  // Walk candidates in priority order; the first requester found wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    w_hit   = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_cand = (i_mode == PRIO_FIXED) ? IW'(k) : IW'((int'(i_ptr) + k) % N);
      w_hit  = !o_any && i_req[w_cand];
      o_grant[w_cand] = o_grant[w_cand] | w_hit;
      o_idx  = w_hit ? w_cand : o_idx;
      o_any  = o_any | w_hit;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master to single-slave memory bus arbiter, one transaction in flight.
// Optional watchdog enabled by defining MEM_BUS_ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 32,
  parameter int PRIO_MODE      = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_MASTERS-1:0]          m_req,
  input  logic [NUM_MASTERS-1:0]          m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_wmask,
  output logic [NUM_MASTERS-1:0]          m_ack,
  output logic [DATA_W-1:0]               m_rdata,
  output logic                            s_valid,
  input  logic                            s_ready,
  output logic                            s_we,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_wmask,
  input  logic                            s_done,
  input  logic [DATA_W-1:0]               s_rdata,
  output logic                            err
);

  localparam int   IW   = idx_w(NUM_MASTERS);
  localparam int   MW   = DATA_W / 8;
  localparam logic MODE = (PRIO_MODE == 1) ? PRIO_FIXED : PRIO_RR;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [IW-1:0]          r_gidx;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [IW-1:0]          r_ptr;
  logic                   r_s_valid;
  logic                   r_s_we;
  logic [ADDR_W-1:0]      r_s_addr;
  logic [DATA_W-1:0]      r_s_wdata;
  logic [MW-1:0]          r_s_wmask;
  logic [NUM_MASTERS-1:0] r_ack;
  logic [DATA_W-1:0]      r_rdata;
  logic                   r_err;

  logic [NUM_MASTERS-1:0] w_grant;
  logic [IW-1:0]          w_idx;
  logic                   w_any;
  logic                   w_complete;
  logic                   w_timeout_hit;
  logic                   w_enter_ack;

  rr_arbiter #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_arb (
    .i_req   (m_req),
    .i_ptr   (r_ptr),
    .i_mode  (MODE),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_complete = ((r_state == ST_ISSUE) && s_ready && s_done) ||
                      ((r_state == ST_WAIT) && s_done);

`ifdef MEM_BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  assign w_timeout_hit = ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) && !w_complete &&
                         (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Watchdog: counts cycles spent waiting on the slave, restarts for each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      r_cnt <= '0;
    end else if ((r_state == ST_ISSUE) || (r_state == ST_WAIT)) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= r_cnt;
    end
  end
`else
  assign w_timeout_hit = 1'b0;
`endif

  // Next-state logic; completion takes precedence over the watchdog.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  w_state_nxt = w_any ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: begin
        if (s_ready && s_done) begin
          w_state_nxt = ST_ACK;
        end else if (w_timeout_hit) begin
          w_state_nxt = ST_ACK;
        end else if (s_ready) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_WAIT:  w_state_nxt = (s_done || w_timeout_hit) ? ST_ACK : ST_WAIT;
      ST_ACK:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_enter_ack = (w_state_nxt == ST_ACK) && (r_state != ST_ACK);

  // State, frozen grant, slave command fields and master response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_gidx    <= '0;
      r_grant   <= '0;
      r_ptr     <= '0;
      r_s_valid <= 1'b0;
      r_s_we    <= 1'b0;
      r_s_addr  <= '0;
      r_s_wdata <= '0;
      r_s_wmask <= '0;
      r_ack     <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= '0;
      r_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gidx    <= w_idx;
            r_grant   <= w_grant;
            r_s_valid <= 1'b1;
            r_s_we    <= m_we[w_idx];
            r_s_addr  <= m_addr[w_idx*ADDR_W +: ADDR_W];
            r_s_wdata <= m_wdata[w_idx*DATA_W +: DATA_W];
            r_s_wmask <= m_wmask[w_idx*MW +: MW];
          end
        end
        ST_ISSUE: begin
          if (s_ready || w_timeout_hit) begin
            r_s_valid <= 1'b0;
          end
        end
        ST_ACK: begin
          r_ptr <= (r_gidx == IW'(NUM_MASTERS - 1)) ? '0 : r_gidx + 1'b1;
        end
        default: ;
      endcase
      if (w_enter_ack) begin
        r_ack <= r_grant;
        if (w_timeout_hit) begin
          r_rdata <= '1;
          r_err   <= 1'b1;
        end else if (!r_s_we) begin
          r_rdata <= s_rdata;
        end
      end
    end
  end

  assign m_ack   = r_ack;
  assign m_rdata = r_rdata;
  assign s_valid = r_s_valid;
  assign s_we    = r_s_we;
  assign s_addr  = r_s_addr;
  assign s_wdata = r_s_wdata;
  assign s_wmask = r_s_wmask;
  assign err     = r_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench: a round-robin instance and a fixed-priority
// instance share all inputs; each step checks hand-computed expectations.
module tb_mem_bus_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   m_req;
  logic [3:0]   m_we;
  logic [95:0]  m_addr;
  logic [127:0] m_wdata;
  logic [15:0]  m_wmask;
  logic         s_ready;
  logic         s_done;
  logic [31:0]  s_rdata;

  logic [3:0]  a_m_ack,  f_m_ack;
  logic [31:0] a_m_rdata, f_m_rdata;
  logic        a_s_valid, f_s_valid;
  logic        a_s_we,    f_s_we;
  logic [23:0] a_s_addr,  f_s_addr;
  logic [31:0] a_s_wdata, f_s_wdata;
  logic [3:0]  a_s_wmask, f_s_wmask;
  logic        a_err,     f_err;

  int errors = 0;
  int checks = 0;
  logic [3:0] ack;
  logic [3:0] exp_ack;

  mem_bus_arbiter #(.NUM_MASTERS(4), .ADDR_W(24), .DATA_W(32), .PRIO_MODE(0), .TIMEOUT_CYCLES(8)) dut_rr (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wmask(m_wmask), .m_ack(a_m_ack), .m_rdata(a_m_rdata), .s_valid(a_s_valid), .s_ready(s_ready),
    .s_we(a_s_we), .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_wmask(a_s_wmask), .s_done(s_done),
    .s_rdata(s_rdata), .err(a_err));

  mem_bus_arbiter #(.NUM_MASTERS(4), .ADDR_W(24), .DATA_W(32), .PRIO_MODE(1), .TIMEOUT_CYCLES(8)) dut_fx (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wmask(m_wmask), .m_ack(f_m_ack), .m_rdata(f_m_rdata), .s_valid(f_s_valid), .s_ready(s_ready),
    .s_we(f_s_we), .s_addr(f_s_addr), .s_wdata(f_s_wdata), .s_wmask(f_s_wmask), .s_done(s_done),
    .s_rdata(s_rdata), .err(f_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Bounded wait for any ack bit on the selected instance; an expired bound returns 0.
  task automatic wait_ack(input bit fx, output logic [3:0] got);
    int n;
    n = 0;
    while (((fx ? f_m_ack : a_m_ack) == 4'b0000) && (n < 16)) begin
      tick();
      n++;
    end
    got = fx ? f_m_ack : a_m_ack;
  endtask

  initial begin
    rst_n   = 1'b0;
    m_req   = 4'b0000;
    m_we    = 4'b0000;
    m_addr  = {24'hC00003, 24'h000100, 24'hA00001, 24'h000040};
    m_wdata = {32'h44444444, 32'h12345678, 32'h22222222, 32'h11111111};
    m_wmask = {4'b1111, 4'b0011, 4'b1100, 4'b0001};
    s_ready = 1'b0;
    s_done  = 1'b0;
    s_rdata = 32'h0000_0000;
    tick();
    tick();
    chk("reset_outputs", {a_m_ack, a_m_rdata, a_s_valid, a_s_we, a_s_addr, a_s_wdata, a_s_wmask, a_err}, 128'd0);
    rst_n = 1'b1;

    // 1: single read from m0, done one cycle after accept
    m_req   = 4'b0001;
    s_ready = 1'b1;
    tick();
    chk("t1_issue_valid", {a_s_valid, a_s_we, a_s_addr}, {1'b1, 1'b0, 24'h000040});
    chk("t1_no_early_ack", a_m_ack, 4'b0000);
    tick();
    chk("t1_wait_valid_low", {a_s_valid, a_m_ack}, {1'b0, 4'b0000});
    s_done  = 1'b1;
    s_rdata = 32'hDEADBEEF;
    tick();
    chk("t1_ack", a_m_ack, 4'b0001);
    chk("t1_rdata", a_m_rdata, 32'hDEADBEEF);
    s_done  = 1'b0;
    s_rdata = 32'h0000_0000;
    m_req   = 4'b0000;
    tick();
    chk("t1_ack_one_cycle", a_m_ack, 4'b0000);
    chk("t1_rdata_hold", a_m_rdata, 32'hDEADBEEF);

    // 2: all masters requesting, round-robin from pointer 0
    do_reset();
    m_req   = 4'b1111;
    s_ready = 1'b1;
    s_done  = 1'b1;
    s_rdata = 32'hA5A5_0000;
    for (int k = 0; k < 5; k++) begin
      exp_ack = 4'b0001 << (k % 4);
      wait_ack(1'b0, ack);
      chk("t2_rr_order", ack, exp_ack);
      chk("t2_rdata", a_m_rdata, 32'hA5A5_0000);
      tick();
      chk("t2_ack_width", a_m_ack, 4'b0000);
    end

    // 3: fixed priority, m0 and m3 requesting; m3 only after m0 drops
    m_req = 4'b0000;
    do_reset();
    m_req = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      wait_ack(1'b1, ack);
      chk("t3_fixed_m0", ack, 4'b0001);
      tick();
    end
    m_req = 4'b1000;
    wait_ack(1'b1, ack);
    chk("t3_fixed_m3_after_drop", ack, 4'b1000);

    // 4: write from m2 with slave stalling five cycles
    m_req = 4'b0000;
    do_reset();
    s_ready = 1'b0;
    s_done  = 1'b0;
    m_we    = 4'b0100;
    m_req   = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_fields_stable", {a_s_valid, a_s_we, a_s_addr, a_s_wdata, a_s_wmask},
          {1'b1, 1'b1, 24'h000100, 32'h12345678, 4'b0011});
    end
    s_ready = 1'b1;
    tick();
    chk("t4_single_accept", a_s_valid, 1'b0);
    s_ready = 1'b0;
    s_done  = 1'b1;
    tick();
    chk("t4_ack_m2", a_m_ack, 4'b0100);
    chk("t4_write_rdata_hold", a_m_rdata, 32'h0000_0000);
    s_done = 1'b0;
    m_req  = 4'b0000;
    m_we   = 4'b0000;
    tick();
    chk("t4_ack_cleared", a_m_ack, 4'b0000);

    // 5: async reset while in WAIT aborts the transaction
    m_req   = 4'b0010;
    s_ready = 1'b1;
    tick();
    tick();
    chk("t5_in_wait", {a_s_valid, a_s_addr, a_m_ack}, {1'b0, 24'hA00001, 4'b0000});
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_reset_outputs", {a_m_ack, a_m_rdata, a_s_valid, a_s_we, a_s_addr, a_s_wdata, a_s_wmask, a_err}, 128'd0);
    m_req  = 4'b0000;
    s_done = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_no_ack_after_reset_a", a_m_ack, 4'b0000);
    tick();
    chk("t5_no_ack_after_reset_b", a_m_ack, 4'b0000);
    m_req = 4'b1111;
    wait_ack(1'b0, ack);
    chk("t5_pointer_zero", ack, 4'b0001);

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    // 6: slave never completes; watchdog forces an error ack
    m_req = 4'b0000;
    do_reset();
    s_done = 1'b0;
    m_req  = 4'b0001;
    wait_ack(1'b0, ack);
    chk("t6_timeout_ack", ack, 4'b0001);
    chk("t6_err", a_err, 1'b1);
    chk("t6_rdata_ones", a_m_rdata, 32'hFFFFFFFF);
    tick();
    chk("t6_err_pulse", {a_err, a_m_ack}, {1'b0, 4'b0000});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
